// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the receive-side symbol-timing controller.
package rx_ctrl_pkg;

    localparam int unsigned NUM_PHASES = 4;
    localparam int unsigned DV_W       = 18;
    localparam int unsigned MAG_W      = DV_W - 1;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StAccum,
        StCompare,
        StDone
    } search_state_e;

    // |dv| as unsigned MAG_W bits; the single most-negative code clamps to full scale.
    function automatic logic [MAG_W-1:0] sat_abs(input logic signed [DV_W-1:0] dv);
        logic [DV_W-1:0] mag;
        if (dv == {1'b1, {(DV_W-1){1'b0}}}) begin
            return {MAG_W{1'b1}};
        end
        mag = dv[DV_W-1] ? (~dv + {{(DV_W-1){1'b0}}, 1'b1}) : dv;
        return mag[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/phase_metric_acc.sv
// Magnitude accumulator for one phase window: sums saturated |dec_var| on enable.
module phase_metric_acc
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned LOG2_SYMS = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          clr_i,
    input  logic                          en_i,
    input  logic signed [DV_W-1:0]        dec_var_i,
    output logic [MAG_W+LOG2_SYMS-1:0]    acc_o
);

    localparam int unsigned ACC_W = MAG_W + LOG2_SYMS;

    logic [ACC_W-1:0] acc_q, acc_d;

    // Clear wins over accumulate; width leaves headroom for 2^LOG2_SYMS full-scale symbols.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(sat_abs(dec_var_i));
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sym_phase_search_ctrl.sv
// Symbol-timing phase search: steps the 4-way sample-phase select, measures the
// mean magnitude per phase, locks the strongest and pulses a downstream clear.
// Optional build macro MANUAL_PHASE_EN adds a manual phase override.
module sym_phase_search_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int unsigned LOG2_SYMS   = 8,
    parameter int unsigned SETTLE_SYMS = 4,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic                          sys_clk_i,
    input  logic                          reset_i,
    input  logic                          sym_clk_en_i,
    input  logic signed [DV_W-1:0]        dec_var_i,
    input  logic                          start_i,
`ifdef MANUAL_PHASE_EN
    input  logic                          manual_en_i,
    input  logic [1:0]                    manual_phase_i,
`endif
    output logic [1:0]                    phase_sel_o,
    output logic                          busy_o,
    output logic                          locked_o,
    output logic                          clr_acc_o,
    output logic [MAG_W+LOG2_SYMS-1:0]    best_metric_o
);

    localparam int unsigned ACC_W = MAG_W + LOG2_SYMS;
    // One counter serves both the settle and accumulate windows.
    localparam int unsigned CNT_W = (LOG2_SYMS > 4) ? LOG2_SYMS : 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SYMS - 1);
    localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'((2 ** LOG2_SYMS) - 1);
    localparam logic [1:0]       PHASE_LAST  = 2'(NUM_PHASES - 1);

    search_state_e    state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       best_idx_q, best_idx_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             auto_pend_q, auto_pend_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [ACC_W-1:0] best_q, best_d;
    logic [ACC_W-1:0] best_metric_q, best_metric_d;

    logic [ACC_W-1:0] acc;
    logic             acc_clr;
    logic             acc_en;

    phase_metric_acc #(
        .LOG2_SYMS (LOG2_SYMS)
    ) u_metric_acc (
        .clk_i     (sys_clk_i),
        .reset_i   (reset_i),
        .clr_i     (acc_clr),
        .en_i      (acc_en),
        .dec_var_i (dec_var_i),
        .acc_o     (acc)
    );

    // State and datapath registers; auto-start request is re-armed by every reset.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            best_idx_q    <= '0;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
            auto_pend_q   <= AUTO_START;
            sym_cnt_q     <= '0;
            best_q        <= '0;
            best_metric_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            best_idx_q    <= best_idx_d;
            busy_q        <= busy_d;
            locked_q      <= locked_d;
            auto_pend_q   <= auto_pend_d;
            sym_cnt_q     <= sym_cnt_d;
            best_q        <= best_d;
            best_metric_q <= best_metric_d;
        end
    end

    // Next-state and datapath updates for the search sequence.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        best_idx_d    = best_idx_q;
        busy_d        = busy_q;
        locked_d      = locked_q;
        auto_pend_d   = auto_pend_q;
        sym_cnt_d     = sym_cnt_q;
        best_d        = best_q;
        best_metric_d = best_metric_q;
        acc_clr       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i || auto_pend_q) begin
                    state_d     = StSettle;
                    phase_d     = '0;
                    busy_d      = 1'b1;
                    locked_d    = 1'b0;
                    best_d      = '0;
                    best_idx_d  = '0;
                    sym_cnt_d   = '0;
                    acc_clr     = 1'b1;
                    auto_pend_d = 1'b0;
                end
            end
            StSettle: begin
                if (sym_clk_en_i) begin
                    if (sym_cnt_q == SETTLE_LAST) begin
                        sym_cnt_d = '0;
                        state_d   = StAccum;
                    end else begin
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    end
                end
            end
            StAccum: begin
                if (sym_clk_en_i) begin
                    if (sym_cnt_q == ACCUM_LAST) begin
                        sym_cnt_d = '0;
                        state_d   = StCompare;
                    end else begin
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    end
                end
            end
            StCompare: begin
                // Strict compare: on a tie the earlier (lower) phase is kept.
                if (acc > best_q) begin
                    best_d     = acc;
                    best_idx_d = phase_q;
                end
                acc_clr = 1'b1;
                if (phase_q == PHASE_LAST) begin
                    state_d = StDone;
                end else begin
                    phase_d = phase_q + 2'd1;
                    state_d = StSettle;
                end
            end
            StDone: begin
                phase_d       = best_idx_q;
                best_metric_d = best_q;
                locked_d      = 1'b1;
                busy_d        = 1'b0;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef MANUAL_PHASE_EN
        // Manual override aborts any search and parks the FSM on the chosen phase.
        if (manual_en_i) begin
            state_d     = StIdle;
            phase_d     = manual_phase_i;
            busy_d      = 1'b0;
            locked_d    = 1'b0;
            auto_pend_d = 1'b0;
            sym_cnt_d   = '0;
            acc_clr     = 1'b1;
        end
`endif
    end

    // Outputs and accumulator enable decoded from the current state.
    always_comb begin
        phase_sel_o   = phase_q;
        busy_o        = busy_q;
        locked_o      = locked_q;
        clr_acc_o     = (state_q == StDone);
        best_metric_o = best_metric_q;
        acc_en        = (state_q == StAccum) && sym_clk_en_i;
`ifdef MANUAL_PHASE_EN
        if (manual_en_i) begin
            phase_sel_o = manual_phase_i;
            busy_o      = 1'b0;
            locked_o    = 1'b0;
            clr_acc_o   = 1'b0;
            acc_en      = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_sym_phase_search_ctrl.sv
// Self-checking bench for sym_phase_search_ctrl (LOG2_SYMS=4, SETTLE_SYMS=2, AUTO_START=1).
module tb_sym_phase_search_ctrl;

    localparam int unsigned L     = 4;
    localparam int unsigned S     = 2;
    localparam int unsigned W     = 16;
    localparam int unsigned ACC_W = 17 + L;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sym_en = 1'b0;
    logic              start = 1'b0;
    logic signed [17:0] dec_var = '0;
    logic [1:0]        phase_sel;
    logic              busy;
    logic              locked;
    logic              clr_acc;
    logic [ACC_W-1:0]  best_metric;
`ifdef MANUAL_PHASE_EN
    logic              manual_en = 1'b0;
    logic [1:0]        manual_phase = 2'd0;
`endif

    sym_phase_search_ctrl #(
        .LOG2_SYMS   (L),
        .SETTLE_SYMS (S),
        .AUTO_START  (1'b1)
    ) dut (
        .sys_clk_i      (clk),
        .reset_i        (reset),
        .sym_clk_en_i   (sym_en),
        .dec_var_i      (dec_var),
        .start_i        (start),
`ifdef MANUAL_PHASE_EN
        .manual_en_i    (manual_en),
        .manual_phase_i (manual_phase),
`endif
        .phase_sel_o    (phase_sel),
        .busy_o         (busy),
        .locked_o       (locked),
        .clr_acc_o      (clr_acc),
        .best_metric_o  (best_metric)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int val;
    } sym_rec_t;

    typedef struct {
        bit     rnd;
        int     v0;
        int     v1;
        int     v2;
        int     v3;
        int     exp_ph;
        longint exp_m;
    } vec_t;

    sym_rec_t log_q[$];
    int       clr_seen = 0;
    int       cyc = 0;
    bit       rnd_mode = 1'b0;
    int       vals[4];
    int       n_tests = 0;
    int       n_fail = 0;
    vec_t     vecs[8];

    function automatic int rand_dv();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -131072;
        if (r == 1) return 131071;
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    function automatic longint mag(input int v);
        if (v == -131072) return 131071;
        return (v < 0) ? -v : v;
    endfunction

    // Phase MUX stand-in plus a log of every symbol the controller should have seen.
    always @(negedge clk) begin
        int v;
        sym_rec_t r;
        cyc++;
        sym_en = (cyc % 4 == 0);
        v = rnd_mode ? rand_dv() : vals[phase_sel];
        dec_var = 18'(v);
        if (sym_en && busy && !reset) begin
            r.ph  = int'(phase_sel);
            r.val = v;
            log_q.push_back(r);
        end
        if (clr_acc) clr_seen++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per phase: first S symbols are discarded, next W summed; best = highest sum, lowest index on tie.
    task automatic model(input int base, output int exp_ph, output longint exp_m,
                         output bit cnt_ok, output int n);
        int     cnt[4];
        longint sum[4];
        for (int p = 0; p < 4; p++) begin
            cnt[p] = 0;
            sum[p] = 0;
        end
        for (int i = base; i < log_q.size(); i++) begin
            int p;
            p = log_q[i].ph;
            if (cnt[p] >= int'(S) && cnt[p] < int'(S + W)) sum[p] += mag(log_q[i].val);
            cnt[p]++;
        end
        exp_ph = 0;
        exp_m  = sum[0];
        cnt_ok = 1'b1;
        for (int p = 0; p < 4; p++) begin
            if (sum[p] > exp_m) begin
                exp_ph = p;
                exp_m  = sum[p];
            end
            if (cnt[p] != int'(S + W)) cnt_ok = 1'b0;
        end
        n = log_q.size() - base;
    endtask

    task automatic set_vec(input int i);
        rnd_mode = vecs[i].rnd;
        vals[0]  = vecs[i].v0;
        vals[1]  = vecs[i].v1;
        vals[2]  = vecs[i].v2;
        vals[3]  = vecs[i].v3;
    endtask

    // Returns while the DONE cycle is visible (clr_acc high).
    task automatic wait_done(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (clr_acc) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, longint'(ok), 1);
    endtask

    // Called in the DONE cycle; checks the locked result one cycle later.
    task automatic finish(input string tag, input int base, input int cb, input int vi,
                          input bit do_idle);
        int     m_ph;
        longint m_m;
        bit     cnt_ok;
        int     n;
        int     e_ph;
        longint e_m;
        @(posedge clk);
        #1;
        model(base, m_ph, m_m, cnt_ok, n);
        e_ph = vecs[vi].rnd ? m_ph : vecs[vi].exp_ph;
        e_m  = vecs[vi].rnd ? m_m : vecs[vi].exp_m;
        check({tag, "_locked"}, longint'(locked), 1);
        check({tag, "_busy_low"}, longint'(busy), 0);
        check({tag, "_clr_low"}, longint'(clr_acc), 0);
        check({tag, "_phase_sel"}, longint'(phase_sel), e_ph);
        check({tag, "_best_metric"}, longint'(best_metric), e_m);
        check({tag, "_clr_pulses"}, clr_seen - cb, 1);
        check({tag, "_busy_syms"}, n, 4 * (S + W));
        check({tag, "_syms_per_phase"}, longint'(cnt_ok), 1);
        if (do_idle) begin
            repeat (12) @(posedge clk);
            #1;
            check({tag, "_metric_hold"}, longint'(best_metric), e_m);
            check({tag, "_lock_hold"}, longint'(locked), 1);
            check({tag, "_clr_once"}, clr_seen - cb, 1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_one(input int vi);
        int    base;
        int    cb;
        bit    ok;
        string tag;
        tag = $sformatf("vec%0d", vi);
        set_vec(vi);
        base = log_q.size();
        cb   = clr_seen;
        pulse_start();
        check({tag, "_start_busy"}, longint'(busy), 1);
        check({tag, "_start_unlock"}, longint'(locked), 0);
        wait_done(tag, ok);
        if (ok) finish(tag, base, cb, vi, 1'b1);
    endtask

    initial begin
        int base;
        int cb;
        bit ok;

        vecs[0] = '{1'b0, 1000, 5000, 3000, -20000, 3, 320000};
        vecs[1] = '{1'b0, 2000, 2000, 2000, 2000, 0, 32000};
        vecs[2] = '{1'b0, 0, -131072, 0, 0, 1, 2097136};
        vecs[3] = '{1'b0, -7, 7, -7, 7, 0, 112};
        for (int i = 4; i < 8; i++) vecs[i] = '{1'b1, 0, 0, 0, 0, -1, -1};

        // Reset state, then auto-start search on vector 0.
        set_vec(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_phase_sel", longint'(phase_sel), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_locked", longint'(locked), 0);
        check("rst_clr_acc", longint'(clr_acc), 0);
        check("rst_best_metric", longint'(best_metric), 0);
        base  = log_q.size();
        cb    = clr_seen;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("auto_start_busy", longint'(busy), 1);
        wait_done("auto", ok);
        if (ok) finish("auto", base, cb, 0, 1'b1);

        for (int i = 1; i < 8; i++) run_one(i);

        // Reset during ACCUM of phase 2 aborts, then auto-start restarts.
        set_vec(0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (phase_sel == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        check("midrst_reach_ph2", longint'(ok), 1);
        repeat ((S + 3) * 4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_phase_sel", longint'(phase_sel), 0);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_locked", longint'(locked), 0);
        check("midrst_clr_acc", longint'(clr_acc), 0);
        reset = 1'b0;
        base  = log_q.size();
        cb    = clr_seen;
        @(posedge clk);
        #1;
        check("midrst_autostart", longint'(busy), 1);
        wait_done("midrst", ok);
        if (ok) finish("midrst", base, cb, 0, 1'b1);

        // Start mid-search and in the DONE cycle are ignored; a start one cycle later is taken.
        set_vec(0);
        base = log_q.size();
        cb   = clr_seen;
        pulse_start();
        repeat (100) @(posedge clk);
        #1;
        pulse_start();
        check("midstart_busy", longint'(busy), 1);
        wait_done("dstart", ok);
        if (ok) begin
            start = 1'b1;
            finish("dstart", base, cb, 0, 1'b0);
            base = log_q.size();
            cb   = clr_seen;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("restart_busy", longint'(busy), 1);
            check("restart_unlock", longint'(locked), 0);
            wait_done("restart", ok);
            if (ok) finish("restart", base, cb, 0, 1'b1);
        end

`ifdef MANUAL_PHASE_EN
        // Manual override during SETTLE takes effect combinationally and blocks start.
        set_vec(0);
        pulse_start();
        @(posedge clk);
        #1;
        manual_phase = 2'd2;
        manual_en    = 1'b1;
        #1;
        check("man_phase_now", longint'(phase_sel), 2);
        check("man_busy", longint'(busy), 0);
        check("man_locked", longint'(locked), 0);
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        check("man_start_ignored", longint'(busy), 0);
        manual_en = 1'b0;
        @(posedge clk);
        #1;
        check("man_phase_held", longint'(phase_sel), 2);
        check("man_idle", longint'(busy), 0);
        run_one(0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d, failed %0d",
                 n_tests, n_fail);
        $fatal(1);
    end

endmodule
